tank_sprite_sched: RTL and testbench
====================================

# tank_sprite_sched

Time-multiplexes the single shared 16x16 tank glyph lookup between two tanks for each displayed pixel. Holds CPU-written tank state (position, facing, flip, visibility) in shadow registers, commits them on frame start to avoid tearing, and produces a per-pixel "tank opaque / which tank" result for the VGA colour mux. Also reports a per-frame tank-overlap (collision) flag to the CPU. Sits between the VGA timing generator and the tank glyph ROM.

## Interface
- COORD_W, 10, width of screen coordinates and tank positions
- SPRITE_SZ, 16, glyph edge in pixels; fixed, glyph index is 4 bits
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  CPU write strobe, one cycle
- wr_tank  in  1  tank select for write (0/1)
- wr_x, wr_y  in  COORD_W  tank top-left position
- wr_dir  in  1  1 = facing right (x mirror)
- wr_flip  in  1  y flip
- wr_vis  in  1  tank visible
- frame_start  in  1  one-cycle pulse from VGA timing, in vertical blanking
- pixel_valid  in  1  pixel request, at most once every 2 clk cycles
- hcount, vcount  in  COORD_W  pixel coordinates, valid with pixel_valid
- glyph_x, glyph_y  out  4  glyph index to shared glyph ROM
- glyph_dir, glyph_flip  out  1  mirror controls to glyph ROM
- glyph_pixel  in  1  combinational glyph ROM result for current outputs
- pix_valid  out  1  one-cycle result strobe
- pix_on  out  1  a tank is opaque at this pixel
- pix_tank  out  1  tank id owning the pixel (0 wins ties)
- collide  out  1  both tanks opaque at some pixel in previous frame
- overrun  out  1  sticky: pixel_valid arrived while in LOOK0

## Operation
- Registers per tank: shadow {x,y,dir,flip,vis} written by wr_en; active copy loaded from all shadows on frame_start. Write and frame_start in same cycle: the written value is committed.
- FSM states IDLE, LOOK0, LOOK1.
  - IDLE: pixel_valid -> capture hcount/vcount into coord regs, go LOOK0.
  - LOOK0: drive glyph for tank 0 from coord regs and tank 0 active state; register hit0 = inbox0 & glyph_pixel; go LOOK1. pixel_valid here: ignored, overrun set.
  - LOOK1: same for tank 1 (hit1); result registered. pixel_valid here: capture new coords, go LOOK0; else IDLE.
- Box test: dx = hcount - x, dy = vcount - y computed COORD_W+1 bits; inbox = vis & no borrow & dx < 16 & dy < 16. glyph_x = dx[3:0], glyph_y = dy[3:0]. No wrap: tank at x = 1020 covers only 1020..1023.
- Result: pix_on = hit0|hit1; pix_tank = hit0 ? 0 : 1 (0 when pix_on = 0).
- Collision: accumulator sets when hit0 & hit1; on frame_start collide <= accumulator (including a hit in that same cycle), accumulator cleared.
- glyph_* outputs in IDLE: zeros.
- overrun clears only on reset.

## Timing
- pixel_valid at cycle t -> LOOK0 at t+1, LOOK1 at t+2, pix_valid with result at t+3. Throughput one pixel per 2 cycles.
- Active-state change from frame_start at t visible to lookups from t+1.
- Reset: FSM IDLE; shadow and active regs all zero (invisible); coord regs, hit regs, accumulator zero; all outputs 0. Reset mid-lookup aborts; no pix_valid for the aborted pixel.

## Structure
- Shared package: COORD_W, SPRITE_SZ, FSM state encoding, tank-state record field widths.
- One sub-module: tank_box_test (coords + tank state -> inbox, glyph_x, glyph_y), instanced once and muxed by state.

## Test plan
- Reset, tank 0 written (x=100,y=50,vis=1), no frame_start; pixel (100,50) -> pix_on=0 (not committed).
- After frame_start, pixel (105,55) with glyph opaque at index (5,5) -> pix_valid at t+3, pix_on=1, pix_tank=0, glyph_x=5, glyph_y=5 during LOOK0.
- Tanks 0 and 1 both at (200,200), opaque pixel (200,200) -> pix_tank=0; after next frame_start collide=1; following frame without overlap -> collide=0.
- Back-to-back pixel_valid every 2 cycles across 32 pixels -> 32 pix_valid pulses, spacing 2, overrun=0; pixel_valid one cycle after another -> overrun=1, second pixel dropped.
- Tank at x=1015, pixel hcount=0 -> pix_on=0 (no wrap); hcount=1023 -> inbox, glyph_x=8.
- reset asserted in LOOK1 -> no pix_valid, all outputs 0 next cycle, tanks invisible.

Source files
------------

// File: rtl/tank_sprite_sched_pkg.sv
// Shared types for the two-tank sprite scheduler:
// coordinate widths, FSM encoding and the tank state record.
package tank_sprite_sched_pkg;

  localparam int COORD_W   = 10;
  localparam int SPRITE_SZ = 16;
  localparam int IDX_W     = $clog2(SPRITE_SZ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOK0,
    S_LOOK1
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               dir;
    logic               flip;
    logic               vis;
  } tank_t;

endpackage

// File: rtl/tank_sprite_sched_box.sv
// Bounding-box test of one pixel against one tank;
// yields glyph index when the pixel lies inside the 16x16 box.
module tank_box_test
  import tank_sprite_sched_pkg::*;
(
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  input  tank_t              tank,
  output logic               inbox,
  output logic [IDX_W-1:0]   gx,
  output logic [IDX_W-1:0]   gy
);

  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;

  // Extra top bit is the borrow: set means pixel left/above the tank
  always_comb begin
    dx    = {1'b0, hc} - {1'b0, tank.x};
    dy    = {1'b0, vc} - {1'b0, tank.y};
    gx    = dx[IDX_W-1:0];
    gy    = dy[IDX_W-1:0];
    inbox = tank.vis
          & ~dx[COORD_W] & ~dy[COORD_W]
          & (dx[COORD_W-1:IDX_W] == '0)
          & (dy[COORD_W-1:IDX_W] == '0);
  end

endmodule

// File: rtl/tank_sprite_sched.sv
// Shares one tank glyph ROM between two tanks per pixel,
// with frame-synchronous state commit and collision flag.
module tank_sprite_sched
  import tank_sprite_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_tank,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic               wr_dir,
  input  logic               wr_flip,
  input  logic               wr_vis,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  output logic [IDX_W-1:0]   glyph_x,
  output logic [IDX_W-1:0]   glyph_y,
  output logic               glyph_dir,
  output logic               glyph_flip,
  input  logic               glyph_pixel,
  output logic               pix_valid,
  output logic               pix_on,
  output logic               pix_tank,
  output logic               collide,
  output logic               overrun
);

  state_e             state_q, state_d;
  tank_t [1:0]        sh_q, sh_d;
  tank_t [1:0]        act_q, act_d;
  logic [COORD_W-1:0] hc_q, hc_d;
  logic [COORD_W-1:0] vc_q, vc_d;
  logic               hit0_q, hit0_d;
  logic               acc_q, acc_d;
  logic               pv_q, pv_d;
  logic               on_q, on_d;
  logic               tk_q, tk_d;
  logic               col_q, col_d;
  logic               ovr_q, ovr_d;

  tank_t              cur;
  logic               inbox;
  logic [IDX_W-1:0]   gx;
  logic [IDX_W-1:0]   gy;
  logic               hit;
  logic               both;

  assign cur = (state_q == S_LOOK1) ? act_q[1] : act_q[0];

  tank_box_test u_box (
    .hc    (hc_q),
    .vc    (vc_q),
    .tank  (cur),
    .inbox (inbox),
    .gx    (gx),
    .gy    (gy)
  );

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    act_d      = act_q;
    hc_d       = hc_q;
    vc_d       = vc_q;
    hit0_d     = hit0_q;
    acc_d      = acc_q;
    col_d      = col_q;
    ovr_d      = ovr_q;
    pv_d       = 1'b0;
    on_d       = 1'b0;
    tk_d       = 1'b0;
    glyph_x    = '0;
    glyph_y    = '0;
    glyph_dir  = 1'b0;
    glyph_flip = 1'b0;
    both       = 1'b0;
    hit        = inbox & glyph_pixel;

    if (wr_en) begin
      sh_d[wr_tank].x    = wr_x;
      sh_d[wr_tank].y    = wr_y;
      sh_d[wr_tank].dir  = wr_dir;
      sh_d[wr_tank].flip = wr_flip;
      sh_d[wr_tank].vis  = wr_vis;
    end
    // Commit sees a same-cycle write
    if (frame_start) act_d = sh_d;

    unique case (state_q)
      S_IDLE: begin
        if (pixel_valid) begin
          hc_d    = hcount;
          vc_d    = vcount;
          state_d = S_LOOK0;
        end
      end
      S_LOOK0: begin
        glyph_x    = gx;
        glyph_y    = gy;
        glyph_dir  = cur.dir;
        glyph_flip = cur.flip;
        hit0_d     = hit;
        ovr_d      = ovr_q | pixel_valid;
        state_d    = S_LOOK1;
      end
      S_LOOK1: begin
        glyph_x    = gx;
        glyph_y    = gy;
        glyph_dir  = cur.dir;
        glyph_flip = cur.flip;
        both       = hit0_q & hit;
        pv_d       = 1'b1;
        on_d       = hit0_q | hit;
        tk_d       = ~hit0_q & hit;
        if (pixel_valid) begin
          hc_d    = hcount;
          vc_d    = vcount;
          state_d = S_LOOK0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_start) begin
      col_d = acc_q | both;
      acc_d = 1'b0;
    end else begin
      acc_d = acc_q | both;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      act_q   <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      hit0_q  <= 1'b0;
      acc_q   <= 1'b0;
      pv_q    <= 1'b0;
      on_q    <= 1'b0;
      tk_q    <= 1'b0;
      col_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      act_q   <= act_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hit0_q  <= hit0_d;
      acc_q   <= acc_d;
      pv_q    <= pv_d;
      on_q    <= on_d;
      tk_q    <= tk_d;
      col_q   <= col_d;
      ovr_q   <= ovr_d;
    end
  end

  assign pix_valid = pv_q;
  assign pix_on    = on_q;
  assign pix_tank  = tk_q;
  assign collide   = col_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_tank_sprite_sched.sv
// Bench for tank_sprite_sched: pixel-level reference model
// plus directed literal checks and randomized traffic.
module tb_tank_sprite_sched;
  import tank_sprite_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_tank = 1'b0;
  logic [9:0] wr_x = '0;
  logic [9:0] wr_y = '0;
  logic       wr_dir = 1'b0;
  logic       wr_flip = 1'b0;
  logic       wr_vis = 1'b0;
  logic       frame_start = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [9:0] hcount = '0;
  logic [9:0] vcount = '0;
  logic [3:0] glyph_x;
  logic [3:0] glyph_y;
  logic       glyph_dir;
  logic       glyph_flip;
  logic       glyph_pixel;
  logic       pix_valid;
  logic       pix_on;
  logic       pix_tank;
  logic       collide;
  logic       overrun;

  tank_sprite_sched dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_tank     (wr_tank),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_dir      (wr_dir),
    .wr_flip     (wr_flip),
    .wr_vis      (wr_vis),
    .frame_start (frame_start),
    .pixel_valid (pixel_valid),
    .hcount      (hcount),
    .vcount      (vcount),
    .glyph_x     (glyph_x),
    .glyph_y     (glyph_y),
    .glyph_dir   (glyph_dir),
    .glyph_flip  (glyph_flip),
    .glyph_pixel (glyph_pixel),
    .pix_valid   (pix_valid),
    .pix_on      (pix_on),
    .pix_tank    (pix_tank),
    .collide     (collide),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Glyph ROM: checkerboard with a solid right-hand strip
  function automatic bit rom(int gx, int gy, bit d, bit f);
    int ix;
    int iy;
    ix = d ? 15 - gx : gx;
    iy = f ? 15 - gy : gy;
    return ((ix % 2) == (iy % 2)) || (ix > 12);
  endfunction

  assign glyph_pixel = rom(int'(glyph_x), int'(glyph_y),
                           glyph_dir, glyph_flip);

  int errors = 0;
  int checks = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask

  typedef struct {
    int x;
    int y;
    bit d;
    bit f;
    bit v;
  } mt_t;

  typedef struct {
    int h;
    int v;
    int t;
    bit h0;
  } rec_t;

  mt_t  msh[2];
  mt_t  mact[2];
  rec_t pend[$];
  int   cur = 0;
  bit   e_pv, e_on, e_tk, e_col, e_ovr, macc;

  function automatic bit mhit(int h, int v, mt_t t);
    int dx;
    int dy;
    dx = h - t.x;
    dy = v - t.y;
    return t.v && dx >= 0 && dx < 16 && dy >= 0 && dy < 16
           && rom(dx, dy, t.d, t.f);
  endfunction

  // Model: a pixel accepted at cycle t is tested against tank 0
  // in cycle t+1, tank 1 in t+2, result visible after that edge.
  always @(posedge clk) begin : model
    rec_t r;
    rec_t nq[$];
    bit   both;
    bit   in0;
    bit   h;
    if (reset) begin
      pend.delete();
      for (int i = 0; i < 2; i++) begin
        msh[i]  = '{0, 0, 0, 0, 0};
        mact[i] = '{0, 0, 0, 0, 0};
      end
      e_pv = 0; e_on = 0; e_tk = 0;
      e_col = 0; e_ovr = 0; macc = 0;
    end else begin
      both = 0; in0 = 0;
      e_pv = 0; e_on = 0; e_tk = 0;
      nq.delete();
      foreach (pend[i]) begin
        r = pend[i];
        if (r.t == cur - 1) begin
          r.h0 = mhit(r.h, r.v, mact[0]);
          in0 = 1;
          nq.push_back(r);
        end else if (r.t == cur - 2) begin
          h    = mhit(r.h, r.v, mact[1]);
          e_pv = 1;
          e_on = r.h0 | h;
          e_tk = !r.h0 && h;
          both = r.h0 && h;
        end
      end
      pend = nq;
      if (pixel_valid) begin
        if (in0) e_ovr = 1;
        else begin
          r.h = int'(hcount); r.v = int'(vcount);
          r.t = cur; r.h0 = 0;
          pend.push_back(r);
        end
      end
      if (frame_start) begin
        e_col = macc | both;
        macc  = 0;
      end else begin
        macc = macc | both;
      end
      if (wr_en)
        msh[wr_tank] = '{int'(wr_x), int'(wr_y), wr_dir, wr_flip, wr_vis};
      if (frame_start) mact = msh;
    end
    cur++;
  end

  int pv_cnt = 0;
  int n_gap2 = 0;
  int last_pv = -100;
  bit last_on;
  bit last_tank;

  always @(negedge clk) begin : compare
    int gx, gy, k;
    bit gd, gf, busy;
    gx = 0; gy = 0; gd = 0; gf = 0; busy = 0; k = 0;
    foreach (pend[i]) begin
      if (pend[i].t == cur - 1) begin k = 0; busy = 1; end
      else if (pend[i].t == cur - 2) begin k = 1; busy = 1; end
      if (busy) begin
        gx = (pend[i].h - mact[k].x) & 15;
        gy = (pend[i].v - mact[k].y) & 15;
        gd = mact[k].d;
        gf = mact[k].f;
        break;
      end
    end
    chk("pix_valid", pix_valid, e_pv);
    if (e_pv) begin
      chk("pix_on", pix_on, e_on);
      chk("pix_tank", pix_tank, e_tk);
    end
    chk("collide", collide, e_col);
    chk("overrun", overrun, e_ovr);
    chk("glyph_x", glyph_x, gx);
    chk("glyph_y", glyph_y, gy);
    chk("glyph_dir", glyph_dir, gd);
    chk("glyph_flip", glyph_flip, gf);
    if (pix_valid) begin
      pv_cnt++;
      if (cur - last_pv == 2) n_gap2++;
      last_pv   = cur;
      last_on   = pix_on;
      last_tank = pix_tank;
    end
  end

  task automatic wr(bit t, int x, int y, bit d, bit f, bit v);
    @(negedge clk);
    wr_en = 1; wr_tank = t;
    wr_x = 10'(x); wr_y = 10'(y);
    wr_dir = d; wr_flip = f; wr_vis = v;
    @(negedge clk);
    wr_en = 0;
  endtask

  task automatic fs();
    @(negedge clk);
    frame_start = 1;
    @(negedge clk);
    frame_start = 0;
  endtask

  task automatic pix(int h, int v);
    @(negedge clk);
    pixel_valid = 1; hcount = 10'(h); vcount = 10'(v);
    @(negedge clk);
    pixel_valid = 0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int n, g;
    repeat (3) @(negedge clk);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_collide", collide, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_glyph_x", glyph_x, 0);
    reset = 0;

    wr(0, 100, 50, 0, 0, 1);
    n = pv_cnt;
    pix(100, 50);
    settle();
    chk("uncommitted_cnt", pv_cnt - n, 1);
    chk("uncommitted_on", last_on, 0);

    fs();
    pix(105, 55);
    chk("look0_glyph_x", glyph_x, 5);
    chk("look0_glyph_y", glyph_y, 5);
    settle();
    chk("hit0_on", last_on, 1);
    chk("hit0_tank", last_tank, 0);

    wr(0, 200, 200, 0, 0, 1);
    wr(1, 200, 200, 1, 0, 1);
    fs();
    pix(200, 200);
    settle();
    chk("tie_on", last_on, 1);
    chk("tie_tank", last_tank, 0);
    fs();
    chk("collide_set", collide, 1);
    pix(250, 250);
    settle();
    fs();
    chk("collide_clr", collide, 0);

    n = pv_cnt;
    g = n_gap2;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pixel_valid = 1;
      hcount = 10'(190 + i); vcount = 10'(205);
      @(negedge clk);
      pixel_valid = 0;
    end
    repeat (4) @(negedge clk);
    chk("burst_cnt", pv_cnt - n, 32);
    chk("burst_gap2", n_gap2 - g, 31);
    chk("burst_overrun", overrun, 0);

    n = pv_cnt;
    @(negedge clk);
    pixel_valid = 1; hcount = 10'(200); vcount = 10'(200);
    @(negedge clk);
    hcount = 10'(201); vcount = 10'(201);
    @(negedge clk);
    pixel_valid = 0;
    repeat (4) @(negedge clk);
    chk("drop_cnt", pv_cnt - n, 1);
    chk("overrun_set", overrun, 1);

    wr(0, 1015, 300, 0, 0, 1);
    fs();
    pix(0, 300);
    settle();
    chk("nowrap_on", last_on, 0);
    pix(1023, 300);
    chk("edge_glyph_x", glyph_x, 8);
    settle();
    chk("edge_on", last_on, 1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wr_en = ($urandom % 6) == 0;
      wr_tank = 1'($urandom);
      wr_x = ($urandom % 8 == 0) ? 10'(1008 + $urandom % 16)
                                 : 10'($urandom % 48);
      wr_y = 10'($urandom % 48);
      wr_dir = 1'($urandom);
      wr_flip = 1'($urandom);
      wr_vis = ($urandom % 4) != 0;
      frame_start = ($urandom % 30) == 0;
      pixel_valid = ($urandom % 5) < 2;
      hcount = ($urandom % 8 == 0) ? 10'(1000 + $urandom % 24)
                                   : 10'($urandom % 64);
      vcount = 10'($urandom % 64);
    end
    @(negedge clk);
    wr_en = 0; frame_start = 0; pixel_valid = 0;

    wr(0, 10, 10, 0, 0, 1);
    wr(1, 10, 10, 0, 0, 1);
    fs();
    n = pv_cnt;
    @(negedge clk);
    pixel_valid = 1; hcount = 10'(10); vcount = 10'(10);
    @(negedge clk);
    pixel_valid = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_pix_valid", pix_valid, 0);
    chk("abort_overrun", overrun, 0);
    chk("abort_glyph_y", glyph_y, 0);
    reset = 0;
    @(negedge clk);
    chk("abort_cnt", pv_cnt - n, 0);
    pix(10, 10);
    settle();
    chk("abort_invisible", last_on, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
